cdiv_iter: RTL and testbench



---
 rtl/cdiv_iter.sv | 154 +++++++++++++++
 tb/tb_cdiv_iter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cdiv_iter.sv
// Iterative fixed-point complex divider: out_q = (opa / opb) << shift, truncated toward zero
// and saturated per component. Restoring division, one quotient bit per cycle for re and im.
module cdiv_iter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] opa,
  input  logic [2*DATA_WIDTH-1:0] opb,
  input  logic [4:0]              shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_q,
  output logic                    out_dz,
  output logic [2:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and out_q/out_dz hold until taken.

  localparam int W  = DATA_WIDTH;
  localparam int NW = 2*W + 1;
  localparam int DW = 2*W + 32;
  localparam int CW = $clog2(DW);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SAT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  a_q, a_d, b_q, b_d;
  logic [4:0]      shift_q, shift_d;
  logic            neg_r_q, neg_r_d, neg_i_q, neg_i_d, dz_q, dz_d;
  logic [NW-1:0]   den_q, den_d, rem_r_q, rem_r_d, rem_i_q, rem_i_d;
  logic [DW-1:0]   dvd_r_q, dvd_r_d, dvd_i_q, dvd_i_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  res_q, res_d;
  logic            res_dz_q, res_dz_d;

  logic signed [NW-1:0] ar_x, ai_x, br_x, bi_x, nr, ni, den_s;
  logic [NW-1:0]        mag_r, mag_i;

  // One restoring step: shift the next dividend bit into the remainder, the quotient bit
  // back into the dividend register's LSB.
  function automatic logic [NW+DW-1:0] div_step(input logic [NW-1:0] rem,
                                                input logic [DW-1:0] dvd,
                                                input logic [NW-1:0] den);
    logic [NW-1:0] rem_sh;
    logic          qbit;
    rem_sh = (rem << 1) | NW'(dvd[DW-1]);
    qbit   = (rem_sh >= den);
    if (qbit) rem_sh = rem_sh - den;
    return {rem_sh, dvd[DW-2:0], qbit};
  endfunction

  function automatic logic [W-1:0] sat(input logic [DW-1:0] q, input logic neg);
    logic [DW-1:0] lim;
    logic [W-1:0]  t;
    lim = neg ? (DW'(1) << (W-1)) : ((DW'(1) << (W-1)) - DW'(1));
    t   = q[W-1:0];
    if (q > lim) return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return neg ? (~t + 1'b1) : t;
  endfunction

  always_comb begin
    ar_x  = $signed({{(W+1){a_q[2*W-1]}}, a_q[2*W-1:W]});
    ai_x  = $signed({{(W+1){a_q[W-1]}},   a_q[W-1:0]});
    br_x  = $signed({{(W+1){b_q[2*W-1]}}, b_q[2*W-1:W]});
    bi_x  = $signed({{(W+1){b_q[W-1]}},   b_q[W-1:0]});
    nr    = ar_x*br_x + ai_x*bi_x;
    ni    = ai_x*br_x - ar_x*bi_x;
    den_s = br_x*br_x + bi_x*bi_x;
    mag_r = nr[NW-1] ? NW'(-nr) : NW'(nr);
    mag_i = ni[NW-1] ? NW'(-ni) : NW'(ni);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_MUL;
      S_MUL:  state_d = (den_s == '0) ? S_SAT : S_DIV;
      S_DIV:  if (cnt_q == CW'(DW-1)) state_d = S_SAT;
      S_SAT:  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out_q     = res_q;
    out_dz    = res_dz_q;
    dbg_state = state_q;
  end

  always_comb begin
    a_d = a_q; b_d = b_q; shift_d = shift_q;
    neg_r_d = neg_r_q; neg_i_d = neg_i_q; dz_d = dz_q; den_d = den_q;
    rem_r_d = rem_r_q; rem_i_d = rem_i_q; dvd_r_d = dvd_r_q; dvd_i_d = dvd_i_q;
    cnt_d = cnt_q; res_d = res_q; res_dz_d = res_dz_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        a_d = opa; b_d = opb; shift_d = shift;
      end
      S_MUL: begin
        neg_r_d = nr[NW-1];
        neg_i_d = ni[NW-1];
        den_d   = NW'(den_s);
        dz_d    = (den_s == '0);
        dvd_r_d = {{(DW-NW){1'b0}}, mag_r} << shift_q;
        dvd_i_d = {{(DW-NW){1'b0}}, mag_i} << shift_q;
        rem_r_d = '0;
        rem_i_d = '0;
        cnt_d   = '0;
      end
      S_DIV: begin
        {rem_r_d, dvd_r_d} = div_step(rem_r_q, dvd_r_q, den_q);
        {rem_i_d, dvd_i_d} = div_step(rem_i_q, dvd_i_q, den_q);
        cnt_d = cnt_q + 1'b1;
      end
      S_SAT: begin
        // Zero denominator: saturate toward the sign of each numerator component.
        if (dz_q)
          res_d = {a_q[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}},
                   a_q[W-1]   ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}};
        else
          res_d = {sat(dvd_r_q, neg_r_q), sat(dvd_i_q, neg_i_q)};
        res_dz_d = dz_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; shift_q <= '0;
      neg_r_q <= 1'b0; neg_i_q <= 1'b0; dz_q <= 1'b0; den_q <= '0;
      rem_r_q <= '0; rem_i_q <= '0; dvd_r_q <= '0; dvd_i_q <= '0;
      cnt_q <= '0; res_q <= '0; res_dz_q <= 1'b0;
    end else begin
      a_q <= a_d; b_q <= b_d; shift_q <= shift_d;
      neg_r_q <= neg_r_d; neg_i_q <= neg_i_d; dz_q <= dz_d; den_q <= den_d;
      rem_r_q <= rem_r_d; rem_i_q <= rem_i_d; dvd_r_q <= dvd_r_d; dvd_i_q <= dvd_i_d;
      cnt_q <= cnt_d; res_q <= res_d; res_dz_q <= res_dz_d;
    end
  end

endmodule

// File: tb/tb_cdiv_iter.sv
// Directed bench for cdiv_iter: hand-computed quotients, latency, backpressure, dz, reset abort.
module tb_cdiv_iter;

  localparam int W   = 16;
  localparam int LAT = 2*W + 32 + 2;

  logic          clk, rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_dz;
  logic [2*W-1:0] opa, opb, out_q;
  logic [4:0]    shift;
  logic [2:0]    dbg_state;

  logic [2*W-1:0] exp_q[$];
  int n_checks, n_errors;

  cdiv_iter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opa(opa), .opb(opb), .shift(shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_q(out_q), .out_dz(out_dz), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Presents one operation, waits for the result, optionally holds out_ready low, then takes it.
  task automatic do_op(input logic [2*W-1:0] a, input logic [2*W-1:0] b, input logic [4:0] sh,
                       input logic [2*W-1:0] eq, input logic edz, input int elat, input int hold);
    int lat;
    logic [2*W-1:0] e;
    exp_q.push_back(eq);
    opa = a; opb = b; shift = sh; in_valid = 1'b1;
    check_val("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; opa = '0; opb = '0; shift = '0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", lat, elat);
    e = exp_q.pop_front();
    check_val("out_q", out_q, e);
    check_val("out_dz", out_dz, edz);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      opa = $urandom; opb = $urandom; shift = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      check_val("hold_out_q", out_q, e);
      check_val("hold_out_valid", out_valid, 1);
      check_val("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("post_out_valid", out_valid, 0);
    check_val("post_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opa = '0; opb = '0; shift = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_q", out_q, 0);
    check_val("rst_out_dz", out_dz, 0);
    check_val("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op({16'h2000, 16'h0000}, {16'h4000, 16'h0000}, 5'd15, {16'h4000, 16'h0000}, 1'b0, LAT, 0);
    do_op({16'h0000, 16'h2000}, {16'h4000, 16'h0000}, 5'd15, {16'h0000, 16'h4000}, 1'b0, LAT, 0);
    do_op({16'hE000, 16'h0000}, {16'h4000, 16'h0000}, 5'd15, {16'hC000, 16'h0000}, 1'b0, LAT, 0);
    do_op({16'h0007, 16'hFFF9}, {16'h0002, 16'h0000}, 5'd0,  {16'h0003, 16'hFFFD}, 1'b0, LAT, 0);
    do_op({16'h4000, 16'h0000}, {16'h0001, 16'h0000}, 5'd15, {16'h7FFF, 16'h0000}, 1'b0, LAT, 0);
    do_op({16'h8000, 16'h0000}, {16'h0001, 16'h0000}, 5'd15, {16'h8000, 16'h0000}, 1'b0, LAT, 0);
    // (3+4j)/(1+2j) * 256 = (2816 - 512j)/5 -> 563, -102
    do_op({16'h0003, 16'h0004}, {16'h0001, 16'h0002}, 5'd8,  {16'h0233, 16'hFF9A}, 1'b0, LAT, 0);
    // 1/(-32768-32768j) << 31: re exactly -32768, im +32768 clamps
    do_op({16'h0001, 16'h0000}, {16'h8000, 16'h8000}, 5'd31, {16'h8000, 16'h7FFF}, 1'b0, LAT, 0);
    do_op({16'h0100, 16'hFF00}, {16'h0000, 16'h0000}, 5'd15, {16'h7FFF, 16'h8000}, 1'b1, 2, 0);
    do_op({16'h0000, 16'h0000}, {16'h0000, 16'h0000}, 5'd0,  {16'h7FFF, 16'h7FFF}, 1'b1, 2, 0);
    do_op({16'h2000, 16'h0000}, {16'h4000, 16'h0000}, 5'd15, {16'h4000, 16'h0000}, 1'b0, LAT, 10);
    do_op({16'h0007, 16'hFFF9}, {16'h0002, 16'h0000}, 5'd0,  {16'h0003, 16'hFFFD}, 1'b0, LAT, 0);

    // Abort with reset at DIV step 20
    opa = {16'h2000, 16'h0000}; opb = {16'h4000, 16'h0000}; shift = 5'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("abort_in_div", dbg_state, 2);
    rst = 1'b1;
    #1;
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_in_ready", in_ready, 1);
    check_val("abort_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_val("abort_no_output", seen, 0);
    do_op({16'hE000, 16'h0000}, {16'h4000, 16'h0000}, 5'd15, {16'hC000, 16'h0000}, 1'b0, LAT, 0);

    check_val("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
